// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR flip-flop command driver: state encoding and default timing.
package sr_drv_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PULSE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StPulse  = PULSE,
    StSettle = SETTLE
  } state_e;

  localparam int unsigned DefPulseCycles  = 1;
  localparam int unsigned DefSettleCycles = 2;
  localparam int unsigned DefMaxRetries   = 1;

endpackage

// File: rtl/sr_phase_counter.sv
// Loadable down-counter with a zero flag; times both the pulse and settle phases.
module sr_phase_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_flop_driver.sv
// Command-side driver for a single SR flip-flop: one-hot set/reset pulse, settle, readback,
// bounded retry, done/err report. All outputs are registered.
module sr_flop_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = DefPulseCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned MAX_RETRIES   = DefMaxRetries
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned PhaseMax = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES
                                                                    : SETTLE_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned RetryW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // The counter is loaded with N-1 so the phase ends on the edge where it reads zero.
  localparam logic [PhaseW-1:0] PulseLoad  = PhaseW'(PULSE_CYCLES - 1);
  localparam logic [PhaseW-1:0] SettleLoad = PhaseW'(SETTLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryInit  = RetryW'(MAX_RETRIES);

  state_e            state_q, state_d;
  logic              level_q, level_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              s_q, s_d, r_q, r_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              cnt_load, cnt_en, cnt_zero;
  logic [PhaseW-1:0] cnt_load_val;

  sr_phase_counter #(
    .Width (PhaseW)
  ) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    retry_d      = retry_q;
    err_d        = err_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = PulseLoad;
    cnt_en       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          level_d = req_level;
          err_d   = 1'b0;
          if (q_fb == req_level) begin
            done_d = 1'b1;
          end else begin
            state_d      = StPulse;
            retry_d      = RetryInit;
            cnt_load     = 1'b1;
            cnt_load_val = PulseLoad;
          end
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d      = StSettle;
          cnt_load     = 1'b1;
          cnt_load_val = SettleLoad;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StSettle: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (q_fb == level_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (retry_q != '0) begin
          retry_d      = retry_q - RetryW'(1);
          state_d      = StPulse;
          cnt_load     = 1'b1;
          cnt_load_val = PulseLoad;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Derived from a single level bit, so s and r can never both be high.
    s_d     = (state_d == StPulse) &&  level_d;
    r_d     = (state_d == StPulse) && !level_d;
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      level_q <= 1'b0;
      retry_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      done_q  <= done_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sr_flop_driver.sv
// Scoreboard bench for sr_flop_driver with a behavioural SR flop (optionally stuck at 0).
module tb_sr_flop_driver;

  logic clk = 1'b0;
  logic reset, req_valid, req_level, req_ready, s, r, q_fb, busy, done, err;
  logic q_model = 1'b0;
  logic stuck = 1'b0;
  logic rand_mode = 1'b0;

  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned viol = 0;
  int unsigned acc_cnt = 0;
  int unsigned done_cnt = 0;

  typedef struct {
    logic        e_err;
    int unsigned e_cyc;
  } exp_t;
  exp_t sb[$];

  sr_flop_driver u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_level (req_level),
    .req_ready (req_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign q_fb = stuck ? 1'b0 : q_model;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s) q_model <= 1'b1;
    else if (r) q_model <= 1'b0;
    if (!reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: invariant every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    if (s && r) begin
      viol++;
      $display("FAIL s_and_r: both high at cycle %0d", cyc);
    end
    if (done) begin
      done_cnt++;
      if (!rand_mode) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_err", err, e.e_err);
          chk("done_cycle", cyc, e.e_cyc);
        end
      end
    end
  end

  // Present a request for one cycle; returns at the negedge of cycle T+1.
  task automatic issue(input logic lvl, input logic push, input logic e_err,
                       input int unsigned lat);
    req_valid = 1'b1;
    req_level = lvl;
    if (push) sb.push_back('{e_err: e_err, e_cyc: cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int unsigned acc0, done0;
    reset = 1'b1; req_valid = 1'b1; req_level = 1'b1;
    // Reset with a request pending: nothing may be accepted.
    repeat (2) begin
      @(negedge clk);
      chk("rst_s", s, 0); chk("rst_r", r, 0); chk("rst_ready", req_ready, 1);
      chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_busy", busy, 0);
    end
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0); chk("post_rst_done", done, 0);

    // Set path: q=0, request 1 -> s at T+1 only, done at T+4.
    issue(1'b1, 1'b1, 1'b0, 4);
    chk("set_s_t1", s, 1); chk("set_r_t1", r, 0); chk("set_busy_t1", busy, 1);
    chk("set_ready_t1", req_ready, 0);
    @(negedge clk);
    chk("set_s_t2", s, 0);
    repeat (4) @(negedge clk);
    chk("set_qfb", q_fb, 1);

    // No-op: q already 1.
    issue(1'b1, 1'b1, 1'b0, 1);
    chk("noop_busy", busy, 0); chk("noop_s", s, 0); chk("noop_r", r, 0);
    @(negedge clk);
    chk("noop_busy2", busy, 0);

    // Stuck-at-0: pulses at T+1 and T+4, done with err at T+7.
    stuck = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 7);
    chk("stuck_s_t1", s, 1);
    @(negedge clk); chk("stuck_s_t2", s, 0);
    repeat (2) @(negedge clk); chk("stuck_s_t4", s, 1);
    repeat (6) @(negedge clk);
    chk("stuck_err_held", err, 1);
    stuck = 1'b0;
    @(negedge clk);
    // q is 1 now; request 0 -> r pulse, err cleared on acceptance.
    issue(1'b0, 1'b1, 1'b0, 4);
    chk("clr_err_t1", err, 0); chk("clr_r_t1", r, 1); chk("clr_s_t1", s, 0);
    repeat (5) @(negedge clk);

    // Abort: set q to 1, then request 0 and reset at T+2.
    issue(1'b1, 1'b1, 1'b0, 4);
    repeat (5) @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, 0);
    chk("abort_r_t1", r, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_s", s, 0); chk("abort_r", r, 0); chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1); chk("abort_done", done, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    issue(1'b1, 1'b1, 1'b0, 4);
    repeat (6) @(negedge clk);
    chk("queue_drained", sb.size(), 0);

    // Random traffic: done count must track acceptances.
    rand_mode = 1'b1;
    acc0 = acc_cnt; done0 = done_cnt;
    for (int i = 0; i < 10000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_level = 1'($urandom_range(0, 1));
      stuck = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    req_valid = 1'b0; stuck = 1'b0;
    repeat (12) @(negedge clk);
    rand_mode = 1'b0;
    chk("done_eq_accepts", done_cnt - done0, acc_cnt - acc0);
    chk("rand_accepts_nonzero", (acc_cnt - acc0) > 100, 1);
    chk("s_and_r_never", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_flop_driver.md
# sr_flop_driver

Command-side driver for the single-bit SR flip-flop (`s`, `r`, `q`). It accepts a requested output level over a valid/ready handshake and emits a clean one-hot set or reset pulse, never `s=r=1`. It then waits a settle window, reads `q` back, retries once on mismatch, and reports done/error. It sits between control logic and the flip-flop, owning every write to that storage element.

## Interface
Parameters:
- `PULSE_CYCLES`, 1, cycles `s` or `r` is held high per attempt (>=1).
- `SETTLE_CYCLES`, 2, cycles waited after the pulse before `q_fb` is compared (>=1).
- `MAX_RETRIES`, 1, extra pulse attempts after a failed compare (>=0).

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_level`  in  1  requested `q` value (1 = set, 0 = reset).
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `s`  out  1  set command to the flip-flop.
- `r`  out  1  reset command to the flip-flop.
- `q_fb`  in  1  flip-flop `q` readback.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  final `q_fb` mismatch; valid with `done`, held until the next acceptance.

## Operation
- States: IDLE, PULSE, SETTLE.
- All outputs are registered.
- Reset values: `s=0`, `r=0`, `done=0`, `err=0`, `busy=0`, `req_ready=1`, state IDLE, counters 0.
- **IDLE, on acceptance:**
  - Latch `req_level` and clear `err`.
  - If `q_fb == req_level` at acceptance, no pulse is issued. `done=1` next cycle, `err=0`, state stays IDLE.
  - Otherwise go to PULSE and load the attempt counter with `MAX_RETRIES`.
- **PULSE:**
  - Drive `s=level`, `r=~level` for exactly `PULSE_CYCLES` cycles.
  - Then drop both and go to SETTLE.
- **SETTLE:**
  - Hold `s=r=0` for `SETTLE_CYCLES` cycles.
  - On the last settle edge, compare `q_fb` with the latched level.
  - Match: go to IDLE, `done=1`, `err=0`.
  - Mismatch with retries remaining: decrement the counter and re-enter PULSE.
  - Mismatch with no retries left: go to IDLE, `done=1`, `err=1`.
- Invariant: `s & r` is never 1 in any cycle, including reset and abort.
- `req_level` and `req_valid` are ignored while busy. There is no queuing.
- Reset mid-operation: the next edge forces `s=r=0` and IDLE and clears `err`. The in-flight request is dropped with no `done`.
- Counter widths: `$clog2(max(PULSE_CYCLES, SETTLE_CYCLES)+1)` for the phase counter, `$clog2(MAX_RETRIES+1)` for the retry counter (minimum 1 bit). Counters down-count and do not wrap.

## Timing
- Acceptance edge is T.
- Pulse cycles: `s`/`r` high in cycles T+1 .. T+P (P = `PULSE_CYCLES`).
- Settle cycles: T+P+1 .. T+P+S (S = `SETTLE_CYCLES`). `q_fb` is sampled on the edge ending cycle T+P+S.
- Success on the first attempt: `done` high in cycle T+P+S+1, the same cycle `req_ready` returns to 1. Back-to-back acceptance is allowed in that cycle.
- Each retry adds P+S cycles. Worst-case latency is (MAX_RETRIES+1)(P+S)+1.
- No-op path: `done` at T+1, `busy` never asserted.

## Structure
- Shared package `sr_drv_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, PULSE=2'd1, SETTLE=2'd2);
  - the default timing constants.
- One sub-module: `sr_phase_counter`. It is a loadable down-counter with a `zero` flag and is reused for both the PULSE and SETTLE phases.
- The FSM and retry logic stay in the top module.

## Test plan
All scenarios use defaults P=1, S=2, R=1 and a behavioural SR flop model in the bench.
- **Reset:** hold `reset` 2 cycles with `req_valid=1` -> `s=r=0`, `req_ready=1`, `done=0`, `err=0`, and nothing is accepted.
- **Set path:** `q_fb=0`, accept `req_level=1` at T -> `s=1` only at T+1, `done=1`/`err=0` at T+4, `q_fb=1`.
- **No-op:** `q_fb=1`, request level 1 -> `done` at T+1, `s=r=0` throughout, `busy` never high.
- **Stuck-at model:** `q_fb` tied 0, request level 1 -> `s` pulses at T+1 and T+4, `done=1`/`err=1` at T+7; the next accepted request clears `err`.
- **Abort:** assert `reset` at T+2 of a reset-level request -> `s=r=0` next cycle, IDLE, no `done`; a fresh request then completes normally.
- **Exhaustive invariant:** random `req_valid`/`req_level` for 10k cycles -> `s&r` never 1, and the `done` count equals the acceptance count.
